// File: rtl/debounce_edge.sv
// debounce_edge: qualifies the synchronized discrete input against a
// programmable stability window. Outputs a clean level and single-cycle
// rise/fall pulses. Define DEBOUNCE_EVCNT_EN to compile in a saturating
// counter of qualified rising edges (cnt_clr, evt_cnt, cnt_sat).
module debounce_edge #(
    parameter int unsigned STABLE_CYC = 16,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sync_in,
    output logic             level_out,
    output logic             rise_pls,
    output logic             fall_pls
`ifdef DEBOUNCE_EVCNT_EN
    ,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] evt_cnt,
    output logic             cnt_sat
`endif
);

    // Reject out-of-range configurations at elaboration time.
    if (STABLE_CYC < 2 || STABLE_CYC > 65535 || CNT_W < 4 || CNT_W > 32) begin : g_bad_cfg
        $error("debounce_edge: STABLE_CYC or CNT_W out of range");
    end

    localparam int unsigned SW = $clog2(STABLE_CYC) + 1;
    localparam logic [SW-1:0] STAB_ONE  = SW'(1);
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYC - 1);

    typedef enum logic [1:0] {
        LO_STABLE,
        LO_CHECK,
        HI_STABLE,
        HI_CHECK
    } state_t;

    state_t        state;
    logic [SW-1:0] stab_cnt;

    // Debounce FSM: a new input value must persist STABLE_CYC samples before
    // the level flips; any return to the old value restarts qualification.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state     <= LO_STABLE;
            stab_cnt  <= '0;
            level_out <= 1'b0;
            rise_pls  <= 1'b0;
            fall_pls  <= 1'b0;
        end else begin
            // Pulses default low so each lasts exactly one cycle.
            rise_pls <= 1'b0;
            fall_pls <= 1'b0;
            case (state)
                LO_STABLE: begin
                    if (sync_in) begin
                        state    <= LO_CHECK;
                        stab_cnt <= STAB_ONE;
                    end
                end
                LO_CHECK: begin
                    if (!sync_in) begin
                        state    <= LO_STABLE;
                        stab_cnt <= '0;
                    end else if (stab_cnt == STAB_LAST) begin
                        state     <= HI_STABLE;
                        stab_cnt  <= '0;
                        level_out <= 1'b1;
                        rise_pls  <= 1'b1;
                    end else begin
                        stab_cnt <= stab_cnt + STAB_ONE;
                    end
                end
                HI_STABLE: begin
                    if (!sync_in) begin
                        state    <= HI_CHECK;
                        stab_cnt <= STAB_ONE;
                    end
                end
                HI_CHECK: begin
                    if (sync_in) begin
                        state    <= HI_STABLE;
                        stab_cnt <= '0;
                    end else if (stab_cnt == STAB_LAST) begin
                        state     <= LO_STABLE;
                        stab_cnt  <= '0;
                        level_out <= 1'b0;
                        fall_pls  <= 1'b1;
                    end else begin
                        stab_cnt <= stab_cnt + STAB_ONE;
                    end
                end
                default: begin
                    state    <= LO_STABLE;
                    stab_cnt <= '0;
                end
            endcase
        end
    end

`ifdef DEBOUNCE_EVCNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] evt_nxt;

    // Next event count: clear wins, but a coincident rise still counts as one.
    always_comb begin
        // NOTE: the default assignment first keeps this block latch-free.
        evt_nxt = evt_cnt;
        if (cnt_clr) begin
            evt_nxt = rise_pls ? CNT_ONE : '0;
        end else if (rise_pls && (evt_cnt != CNT_MAX)) begin
            evt_nxt = evt_cnt + CNT_ONE;
        end
    end

    // Register the count and its saturation flag together.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_cnt <= '0;
            cnt_sat <= 1'b0;
        end else begin
            evt_cnt <= evt_nxt;
            cnt_sat <= (evt_nxt == CNT_MAX);
        end
    end
`endif

endmodule

// File: tb/tb_debounce_edge.sv
// Testbench for debounce_edge: directed scenarios followed by randomized
// input segments, all compared cycle by cycle against a run-length model.
// Counter checks are active when DEBOUNCE_EVCNT_EN is defined.
module tb_debounce_edge;

    localparam int S    = 16;
    localparam int CW   = 4;
    localparam int MAXV = (1 << CW) - 1;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic sync_in = 1'b0;
    logic cnt_clr = 1'b0;
    logic level_out, rise_pls, fall_pls;
`ifdef DEBOUNCE_EVCNT_EN
    logic [CW-1:0] evt_cnt;
    logic          cnt_sat;
`endif

    always #5 clk = ~clk;

    debounce_edge #(.STABLE_CYC(S), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .sync_in  (sync_in),
        .level_out(level_out),
        .rise_pls (rise_pls),
        .fall_pls (fall_pls)
`ifdef DEBOUNCE_EVCNT_EN
        ,
        .cnt_clr  (cnt_clr),
        .evt_cnt  (evt_cnt),
        .cnt_sat  (cnt_sat)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: accepted level plus length of the current run of
    // samples that disagree with it.
    bit m_lvl  = 0;
    bit m_rise = 0;
    bit m_fall = 0;
    int m_run  = 0;
    int m_evt  = 0;
    bit m_sat  = 0;

    int rise_seen     = 0;
    int fall_seen     = 0;
    int last_rise_cyc = 0;
    int start_cyc     = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model, then compare outputs.
    task automatic step(input bit s, input bit r, input bit c);
        sync_in = s;
        rst     = r;
        cnt_clr = c;
        @(posedge clk);
        cyc++;
        // Counter reacts to the pulse that was visible before this edge.
        if (r)                              m_evt = 0;
        else if (c)                         m_evt = m_rise ? 1 : 0;
        else if (m_rise && m_evt < MAXV)    m_evt = m_evt + 1;
        m_sat = (m_evt == MAXV);
        if (r) begin
            m_lvl = 0; m_run = 0; m_rise = 0; m_fall = 0;
        end else if (s != m_lvl) begin
            m_run++;
            m_rise = 0; m_fall = 0;
            if (m_run == S) begin
                m_lvl  = s;
                m_rise = s;
                m_fall = !s;
                m_run  = 0;
            end
        end else begin
            m_run = 0; m_rise = 0; m_fall = 0;
        end
        #1;
        check("level_out", 32'(level_out), 32'(m_lvl));
        check("rise_pls",  32'(rise_pls),  32'(m_rise));
        check("fall_pls",  32'(fall_pls),  32'(m_fall));
`ifdef DEBOUNCE_EVCNT_EN
        check("evt_cnt",   32'(evt_cnt),   32'(m_evt));
        check("cnt_sat",   32'(cnt_sat),   32'(m_sat));
`endif
        if (rise_pls === 1'b1) begin
            rise_seen++;
            last_rise_cyc = cyc;
        end
        if (fall_pls === 1'b1) fall_seen++;
    endtask

    task automatic run(input bit s, input int n);
        for (int i = 0; i < n; i++) step(s, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset, then a quiet input.
        repeat (3) step(1'b0, 1'b1, 1'b0);
        rise_seen = 0; fall_seen = 0;
        run(1'b0, 40);
        check("quiet_pulses", 32'(rise_seen + fall_seen), 32'd0);

        // Rise and hold: level appears S cycles after the first 1 sample.
        rise_seen = 0;
        start_cyc = cyc + 1;
        run(1'b1, 20);
        check("rise_count", 32'(rise_seen), 32'd1);
        check("rise_latency", 32'(last_rise_cyc - start_cyc + 1), 32'(S));

        // Drop of S-1 samples is rejected; drop of S samples is accepted.
        fall_seen = 0;
        run(1'b0, S - 1);
        run(1'b1, 5);
        check("glitch_fall", 32'(fall_seen), 32'd0);
        check("glitch_level", 32'(level_out), 32'd1);
        run(1'b0, S);
        check("fall_count", 32'(fall_seen), 32'd1);
        check("fall_level", 32'(level_out), 32'd0);

`ifdef DEBOUNCE_EVCNT_EN
        // Saturation after 17 qualified rises, then clear coincident with a rise.
        step(1'b0, 1'b0, 1'b1);
        check("evt_cleared", 32'(evt_cnt), 32'd0);
        for (int k = 0; k < 17; k++) begin
            run(1'b1, S);
            run(1'b0, S);
        end
        check("sat_cnt", 32'(evt_cnt), 32'(MAXV));
        check("sat_flag", 32'(cnt_sat), 32'd1);
        for (int i = 0; i < S + 2; i++) step(1'b1, 1'b0, m_rise);
        check("clr_with_rise_cnt", 32'(evt_cnt), 32'd1);
        check("clr_with_rise_sat", 32'(cnt_sat), 32'd0);
        run(1'b0, S + 2);
`endif

        // Reset mid-check aborts; a held-high input needs a full window again.
        run(1'b0, 2);
        rise_seen = 0;
        run(1'b1, 10);
        step(1'b1, 1'b1, 1'b0);
        check("abort_rise", 32'(rise_seen), 32'd0);
        start_cyc = cyc + 1;
        run(1'b1, 20);
        check("post_rst_rise", 32'(rise_seen), 32'd1);
        check("post_rst_latency", 32'(last_rise_cyc - start_cyc + 1), 32'(S));

        // Randomized segments with occasional reset and counter clear.
        start_cyc = cyc;
        while (cyc < start_cyc + 3000) begin
            bit v;
            int len;
            v   = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(S - 3, S + 3))
                                              : int'($urandom_range(1, 40));
            for (int i = 0; i < len; i++)
                step(v, ($urandom_range(0, 299) == 0), ($urandom_range(0, 39) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
